// File: rtl/top_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module      : top_writeback_pkg
// Description : Shared constants and types for the WriteBack stage: decoded
//               opcode field positions, write-back select encodings and the
//               retired-instruction counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package top_writeback_pkg;

  // Datapath width default; RV64I builds widen the core to 64 bits.
`ifdef RV64I
  localparam int XLEN_DEFAULT = 64;
`else
  localparam int XLEN_DEFAULT = 32;
`endif

  // Decoded opcode layout shared with Decode/Execute/MemoryAccess.
  localparam int OPLEN        = 8;
  localparam int RD_WE_BIT    = 0;
  localparam int WB_SEL_BIT_L = 1;
  localparam int WB_SEL_BIT_M = 2;

  // Retired-instruction counter is architecturally 64 bits on all XLENs.
  localparam int INSTRET_LEN  = 64;

  // Write-back source select; code 0 means "no register write".
  typedef enum logic [1:0] {
    WB_SEL_NONE = 2'd0,
    WB_SEL_ALU  = 2'd1,
    WB_SEL_MEM  = 2'd2,
    WB_SEL_PC   = 2'd3
  } wb_sel_e;

  // True when the select code names a real write-back source.
  function automatic logic wb_sel_valid(input wb_sel_e sel);
    return (sel == WB_SEL_ALU) || (sel == WB_SEL_MEM) || (sel == WB_SEL_PC);
  endfunction

endpackage : top_writeback_pkg
`default_nettype wire

// File: rtl/top_writeback_if.sv
`default_nettype none
// ============================================================================
// Module      : top_writeback_if
// Description : MemoryAccess -> WriteBack latch bundle plus the WriteBack
//               phase enable. MemoryAccess (and the StateMachine phase) drive
//               through the master modport; WriteBack consumes via slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface top_writeback_if
  import top_writeback_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);

  logic             phase_writeback;
  logic [OPLEN-1:0] decoded_op_mw;
  logic             jump_state_mw;
  logic [4:0]       rdsel_mw;
  logic [XLEN-1:0]  next_pc_mw;
  logic [XLEN-1:0]  alu_out_mw;
  logic [XLEN-1:0]  mem_out_mw;

  modport master (
    output phase_writeback,
    output decoded_op_mw,
    output jump_state_mw,
    output rdsel_mw,
    output next_pc_mw,
    output alu_out_mw,
    output mem_out_mw
  );

  modport slave (
    input phase_writeback,
    input decoded_op_mw,
    input jump_state_mw,
    input rdsel_mw,
    input next_pc_mw,
    input alu_out_mw,
    input mem_out_mw
  );

endinterface : top_writeback_if
`default_nettype wire

// File: rtl/top_writeback_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : 31 x XLEN integer register file (x1..x31), x0 hardwired to
//               zero. One synchronous write port with synchronous clear and
//               two asynchronous read ports without write bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile #(
  parameter int XLEN = 32
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            we,
  input  wire logic [4:0]      waddr,
  input  wire logic [XLEN-1:0] wdata,
  input  wire logic [4:0]      raddr1,
  input  wire logic [4:0]      raddr2,
  output logic      [XLEN-1:0] rdata1,
  output logic      [XLEN-1:0] rdata2
);

  // Storage starts at index 1: x0 has no flops at all.
  logic [XLEN-1:0] regs_q [1:31];
  logic [XLEN-1:0] regs_d [1:31];

  // Next register contents: hold everything, overwrite the addressed entry.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != 5'd0)) begin
      regs_d[waddr] = wdata;
    end
  end

  // Register storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Asynchronous reads; index 0 always returns zero. A same-edge write is
  // not forwarded -- Decode is phase-sequenced never to need it.
  always_comb begin
    rdata1 = (raddr1 == 5'd0) ? '0 : regs_q[raddr1];
    rdata2 = (raddr2 == 5'd0) ? '0 : regs_q[raddr2];
  end

endmodule : wb_regfile
`default_nettype wire

// File: rtl/top_writeback.sv
`default_nettype none
// ============================================================================
// Module      : top_writeback
// Description : WriteBack stage. Selects the write-back value (ALU result,
//               load data or return address), writes the integer register
//               file, and owns the architectural PC and retired-instruction
//               counter. All state advances only in the WriteBack phase.
// Revision    : 1.0 - initial release
// ============================================================================
module top_writeback
  import top_writeback_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  top_writeback_if.slave              mw,
  input  wire logic [4:0]             rs1sel,
  input  wire logic [4:0]             rs2sel,
  output logic      [XLEN-1:0]        rs1data,
  output logic      [XLEN-1:0]        rs2data,
  output logic      [XLEN-1:0]        current_pc,
  output logic      [INSTRET_LEN-1:0] instret,
  output logic                        stall_writeback
);

  logic                   rd_we;
  wb_sel_e                wb_sel;
  logic                   wb_valid;
  logic [XLEN-1:0]        wb_data;
  logic                   reg_we;
  logic [XLEN-1:0]        pc_plus4;
  logic [XLEN-1:0]        current_pc_d;
  logic [XLEN-1:0]        current_pc_q;
  logic [INSTRET_LEN-1:0] instret_d;
  logic [INSTRET_LEN-1:0] instret_q;
  logic                   unused_op_bits;

  // Opcode fields this stage cares about; the rest belong to other stages.
  assign rd_we          = mw.decoded_op_mw[RD_WE_BIT];
  assign wb_sel         = wb_sel_e'(mw.decoded_op_mw[WB_SEL_BIT_M:WB_SEL_BIT_L]);
  assign unused_op_bits = ^mw.decoded_op_mw[OPLEN-1:WB_SEL_BIT_M+1];

  // Return address is based on the pre-update PC and wraps at XLEN.
  assign pc_plus4 = current_pc_q + XLEN'(4);

  // Write-back source mux; unknown select codes suppress the write.
  always_comb begin
    wb_data  = '0;
    wb_valid = wb_sel_valid(wb_sel);
    case (wb_sel)
      WB_SEL_ALU: wb_data = mw.alu_out_mw;
      WB_SEL_MEM: wb_data = mw.mem_out_mw;
      WB_SEL_PC:  wb_data = pc_plus4;
      default:    wb_data = '0;
    endcase
  end

  // Register write strobe; rdsel 0 is filtered here and again in the file.
  assign reg_we = mw.phase_writeback & rd_we & wb_valid & (mw.rdsel_mw != 5'd0);

  // Next PC and retired count: advance only in the WriteBack phase.
  always_comb begin
    current_pc_d = current_pc_q;
    instret_d    = instret_q;
    if (mw.phase_writeback) begin
      current_pc_d = mw.jump_state_mw ? mw.next_pc_mw : pc_plus4;
      instret_d    = instret_q + INSTRET_LEN'(1);
    end
  end

  // Architectural PC and instret registers; reset overrides any phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      current_pc_q <= RESET_VECTOR;
      instret_q    <= '0;
    end else begin
      current_pc_q <= current_pc_d;
      instret_q    <= instret_d;
    end
  end

  wb_regfile #(
    .XLEN (XLEN)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (reg_we),
    .waddr  (mw.rdsel_mw),
    .wdata  (wb_data),
    .raddr1 (rs1sel),
    .raddr2 (rs2sel),
    .rdata1 (rs1data),
    .rdata2 (rs2data)
  );

  assign current_pc      = current_pc_q;
  assign instret         = instret_q;
  assign stall_writeback = 1'b0;

endmodule : top_writeback
`default_nettype wire

// File: tb/tb_top_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_top_writeback
// Description : Directed scoreboard bench for top_writeback. The driver
//               issues write-back transactions and queues the expected
//               architectural state; a monitor compares it on the falling
//               edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_top_writeback;
  import top_writeback_pkg::*;

  localparam int XLEN = 32;

  // Hand-encoded opcodes: bit0 = rd_we, bits[2:1] = wb_sel.
  localparam logic [OPLEN-1:0] OP_NOP      = 8'h00;
  localparam logic [OPLEN-1:0] OP_WE_NOSEL = 8'h01;
  localparam logic [OPLEN-1:0] OP_ALU_NOWE = 8'h02;
  localparam logic [OPLEN-1:0] OP_ALU      = 8'h03;
  localparam logic [OPLEN-1:0] OP_MEM      = 8'h05;
  localparam logic [OPLEN-1:0] OP_JAL      = 8'h07;

  localparam int K_RS1 = 0, K_RS2 = 1, K_PC = 2, K_IR = 3, K_STALL = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       rs1sel;
  logic [4:0]       rs2sel;
  logic [XLEN-1:0]  rs1data;
  logic [XLEN-1:0]  rs2data;
  logic [XLEN-1:0]  current_pc;
  logic [63:0]      instret;
  logic             stall_writeback;

  int vectors     = 0;
  int miscompares = 0;

  string       exp_name [$];
  int          exp_kind [$];
  logic [63:0] exp_val  [$];

  top_writeback_if #(.XLEN(XLEN)) mw_bus ();

  top_writeback #(.XLEN(XLEN), .RESET_VECTOR('0)) dut (
    .clk             (clk),
    .rst             (rst),
    .mw              (mw_bus),
    .rs1sel          (rs1sel),
    .rs2sel          (rs2sel),
    .rs1data         (rs1data),
    .rs2data         (rs2data),
    .current_pc      (current_pc),
    .instret         (instret),
    .stall_writeback (stall_writeback)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string n, input int k, input logic [63:0] v);
    exp_name.push_back(n);
    exp_kind.push_back(k);
    exp_val.push_back(v);
  endtask

  // Select two registers and queue the full expected visible state.
  task automatic check_state(input string tag,
                             input logic [4:0] a, input logic [31:0] va,
                             input logic [4:0] b, input logic [31:0] vb,
                             input logic [31:0] pc, input logic [63:0] ir);
    rs1sel = a;
    rs2sel = b;
    push_exp({tag, ".rs1"},   K_RS1,   {32'h0, va});
    push_exp({tag, ".rs2"},   K_RS2,   {32'h0, vb});
    push_exp({tag, ".pc"},    K_PC,    {32'h0, pc});
    push_exp({tag, ".ir"},    K_IR,    ir);
    push_exp({tag, ".stall"}, K_STALL, 64'h0);
    tick();
  endtask

  task automatic set_fields(input logic [OPLEN-1:0] op, input logic [4:0] rd,
                            input logic jump, input logic [31:0] npc,
                            input logic [31:0] alu, input logic [31:0] mem);
    mw_bus.decoded_op_mw = op;
    mw_bus.rdsel_mw      = rd;
    mw_bus.jump_state_mw = jump;
    mw_bus.next_pc_mw    = npc;
    mw_bus.alu_out_mw    = alu;
    mw_bus.mem_out_mw    = mem;
  endtask

  // One WriteBack phase pulse carrying the given transaction.
  task automatic pulse(input logic [OPLEN-1:0] op, input logic [4:0] rd,
                       input logic jump, input logic [31:0] npc,
                       input logic [31:0] alu, input logic [31:0] mem);
    set_fields(op, rd, jump, npc, alu, mem);
    mw_bus.phase_writeback = 1'b1;
    tick();
    mw_bus.phase_writeback = 1'b0;
  endtask

  // Monitor: drain and compare queued expectations on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_kind.size() > 0) begin
        string       n;
        int          k;
        logic [63:0] e;
        logic [63:0] act;
        n = exp_name.pop_front();
        k = exp_kind.pop_front();
        e = exp_val.pop_front();
        case (k)
          K_RS1:   act = {32'h0, rs1data};
          K_RS2:   act = {32'h0, rs2data};
          K_PC:    act = {32'h0, current_pc};
          K_IR:    act = instret;
          default: act = {63'h0, stall_writeback};
        endcase
        vectors++;
        if (act !== e) begin
          miscompares++;
          $display("FAIL %s: got %h expected %h", n, act, e);
        end
      end
    end
  end

  initial begin
    rst    = 1'b1;
    rs1sel = 5'd0;
    rs2sel = 5'd0;
    mw_bus.phase_writeback = 1'b0;
    set_fields(OP_NOP, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);

    // Reset for two cycles, then release.
    tick();
    tick();
    rst = 1'b0;
    check_state("reset", 5'd5, 32'h0, 5'd0, 32'h0, 32'h0, 64'd0);

    // ALU write-back to x3.
    pulse(OP_ALU, 5'd3, 1'b0, 32'h0, 32'h0000_1234, 32'h0);
    check_state("alu", 5'd3, 32'h0000_1234, 5'd0, 32'h0, 32'h4, 64'd1);

    // Load to x7, then the same load aimed at x0.
    pulse(OP_MEM, 5'd7, 1'b0, 32'h0, 32'h0, 32'hFFFF_FF80);
    check_state("load", 5'd7, 32'hFFFF_FF80, 5'd3, 32'h0000_1234, 32'h8, 64'd2);
    pulse(OP_MEM, 5'd0, 1'b0, 32'h0, 32'h0, 32'hFFFF_FF80);
    check_state("x0", 5'd0, 32'h0, 5'd7, 32'hFFFF_FF80, 32'hC, 64'd3);

    // Jump to 0x100 without a write, then JAL to 0x200 linking into x1.
    pulse(OP_NOP, 5'd9, 1'b1, 32'h100, 32'hAAAA_AAAA, 32'h0);
    check_state("jmp", 5'd9, 32'h0, 5'd1, 32'h0, 32'h100, 64'd4);
    pulse(OP_JAL, 5'd1, 1'b1, 32'h200, 32'h0, 32'h0);
    check_state("jal", 5'd1, 32'h104, 5'd3, 32'h0000_1234, 32'h200, 64'd5);

    // rd_we clear, and rd_we set with the "none" select: neither writes.
    pulse(OP_ALU_NOWE, 5'd4, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h0);
    check_state("nowe", 5'd4, 32'h0, 5'd1, 32'h104, 32'h204, 64'd6);
    pulse(OP_WE_NOSEL, 5'd5, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h1111_1111);
    check_state("nosel", 5'd5, 32'h0, 5'd7, 32'hFFFF_FF80, 32'h208, 64'd7);

    // Write op held five cycles with the phase low: nothing changes.
    set_fields(OP_ALU, 5'd3, 1'b1, 32'h400, 32'h0000_BEEF, 32'h0);
    repeat (5) tick();
    check_state("gate", 5'd3, 32'h0000_1234, 5'd7, 32'hFFFF_FF80, 32'h208, 64'd7);

    // Reset together with a phase pulse: reset wins, no write.
    rst = 1'b1;
    mw_bus.phase_writeback = 1'b1;
    tick();
    rst = 1'b0;
    mw_bus.phase_writeback = 1'b0;
    check_state("rstpri", 5'd3, 32'h0, 5'd7, 32'h0, 32'h0, 64'd0);
    check_state("rstpri2", 5'd1, 32'h0, 5'd31, 32'h0, 32'h0, 64'd0);

    // PC wrap: park at 0xFFFFFFFC and let the return address wrap too.
    pulse(OP_ALU, 5'd2, 1'b0, 32'h0, 32'h0000_0055, 32'h0);
    check_state("pre2", 5'd2, 32'h55, 5'd0, 32'h0, 32'h4, 64'd1);
    pulse(OP_NOP, 5'd0, 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0);
    check_state("park", 5'd2, 32'h55, 5'd31, 32'h0, 32'hFFFF_FFFC, 64'd2);
    pulse(OP_JAL, 5'd2, 1'b0, 32'h1234_5678, 32'h0, 32'h0);
    check_state("pcwrap", 5'd2, 32'h0, 5'd0, 32'h0, 32'h0, 64'd3);

    // instret wrap from all-ones.
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    check_state("irmax", 5'd0, 32'h0, 5'd2, 32'h0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    pulse(OP_NOP, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    check_state("irwrap", 5'd0, 32'h0, 5'd0, 32'h0, 32'h4, 64'd0);

    // Bounded wait for the monitor to drain.
    for (int i = 0; i < 10 && exp_kind.size() > 0; i++) tick();
    if (exp_kind.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_kind.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_top_writeback
`default_nettype wire
